opb_register_ppc2simulink: RTL and testbench

- OPB slave register written by the PPC and driven into fabric user logic; the opposite direction of the simulink2ppc readback registers.
- Holds one 32-bit control word (byte-enable writable, readable back) plus a read-only write counter.
- Pulses a one-cycle update strobe to user logic on every committed write.
- Single clock domain (OPB_Clk); user logic consuming user_data_out must run on OPB_Clk.

---
 rtl/opb_register_ppc2simulink.sv | 116 +++++++++++
 tb/tb_opb_register_ppc2simulink.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave control register written by the PPC and driven into fabric logic.
// Holds a byte-writable control word plus a read-only count of committed writes.
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter logic [63:0] C_FAMILY     = "virtex6",
  parameter logic [31:0] C_DEFAULT    = 32'h0000_0000
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic                        Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [31:0]                 user_data_out,
  output logic                        user_data_update
);

  typedef enum logic [1:0] {StIdle, StAck, StGap} state_e;

  state_e      state_q, state_d;
  logic        rnw_q;
  logic        wsel_q;     // 1 selects WCOUNT, 0 selects CTRL
  logic [0:3]  be_q;
  logic [0:31] wdata_q;
  logic [0:31] ctrl_q, ctrl_d;
  logic [31:0] wcount_q;
  logic        update_q;
  logic        hit, commit;

  // Window test via borrow bits so a zero base does not degenerate into a constant compare.
  logic [32:0] lo_diff, hi_diff;
  assign lo_diff = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
  assign hi_diff = {1'b0, C_HIGHADDR} - {1'b0, OPB_ABus};
  assign hit     = OPB_select & ~lo_diff[32] & ~hi_diff[32];

  logic unused_bits;
  assign unused_bits = ^{OPB_seqAddr, |C_FAMILY, lo_diff[31:0], hi_diff[31:0]};

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hit) state_d = StAck;
      StAck:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Sl_xferAck = 1'b0;
    Sl_DBus    = '0;
    if (state_q == StAck) begin
      Sl_xferAck = 1'b1;
      if (rnw_q) Sl_DBus = wsel_q ? wcount_q : ctrl_q;
    end
  end

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign commit = (state_q == StAck) & ~rnw_q & ~wsel_q & (|be_q);

  always_comb begin
    ctrl_d = ctrl_q;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) ctrl_d[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      rnw_q    <= 1'b1;
      wsel_q   <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      ctrl_q   <= C_DEFAULT;
      wcount_q <= '0;
      update_q <= 1'b0;
    end else begin
      if (state_q == StIdle && hit) begin
        rnw_q   <= OPB_RNW;
        wsel_q  <= OPB_ABus[29];
        be_q    <= OPB_BE;
        wdata_q <= OPB_DBus;
      end
      if (commit) begin
        ctrl_q   <= ctrl_d;
        wcount_q <= wcount_q + 32'd1;
      end
      update_q <= commit;
    end
  end

  assign user_data_out    = ctrl_q;
  assign user_data_update = update_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Randomized self-checking bench for opb_register_ppc2simulink against a
// transaction-level model of the control word and write counter.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] Base = 32'h0000_1000;
  localparam logic [31:0] High = 32'h0000_10FF;
  localparam logic [31:0] Def  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] sl_dbus;
  logic        sl_err_ack, sl_retry, sl_tout_sup, sl_xfer_ack;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw, sel, seq_addr;
  logic [31:0] udo;
  logic        upd;

  opb_register_ppc2simulink #(
    .C_BASEADDR  (Base),
    .C_HIGHADDR  (High),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_FAMILY    ("virtex6"),
    .C_DEFAULT   (Def)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .Sl_DBus         (sl_dbus),
    .Sl_errAck       (sl_err_ack),
    .Sl_retry        (sl_retry),
    .Sl_toutSup      (sl_tout_sup),
    .Sl_xferAck      (sl_xfer_ack),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq_addr),
    .user_data_out   (udo),
    .user_data_update(upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ctrl_m;
  logic [31:0] wcount_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // b[3] is the OPB BE[0] lane, i.e. the most significant byte.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic xfer(input logic [31:0] addr, input bit rd, input logic [3:0] be_v,
                      input logic [31:0] data);
    int          lat;
    bit          got;
    bit          is_ctrl;
    bit          commit;
    logic [31:0] exp_rd;
    is_ctrl = ~addr[2];
    exp_rd  = is_ctrl ? ctrl_m : wcount_m;
    @(negedge clk);
    abus = addr; rnw = rd; be = be_v; dbus = data; sel = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (sl_xfer_ack) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check_eq("ack_latency", got ? lat : 0, 1);
    if (!got) begin
      sel = 1'b0;
      return;
    end
    check_eq("rd_data", sl_dbus, rd ? exp_rd : 32'h0);
    sel = 1'b0;
    commit = !rd && is_ctrl && (be_v != 4'h0);
    if (commit) begin
      ctrl_m   = merge(ctrl_m, data, be_v);
      wcount_m = wcount_m + 32'd1;
    end
    @(negedge clk);
    check_eq("ack_width", {31'h0, sl_xfer_ack}, 0);
    check_eq("user_data_out", udo, ctrl_m);
    check_eq("update_pulse", {31'h0, upd}, {31'h0, commit});
    check_eq("gap_dbus", sl_dbus, 0);
  endtask

  task automatic out_of_window(input logic [31:0] addr, input int n);
    @(negedge clk);
    abus = addr; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("oow_ack", {31'h0, sl_xfer_ack}, 0);
      check_eq("oow_dbus", sl_dbus, 0);
    end
    sel = 1'b0;
  endtask

  task automatic back_to_back(input int n);
    int prev;
    int acks;
    bit got;
    logic [31:0] cur;
    prev = -1;
    acks = 0;
    @(negedge clk);
    cur = $urandom;
    abus = Base; rnw = 1'b0; be = 4'hF; dbus = cur; sel = 1'b1;
    while (acks < n) begin
      got = 1'b0;
      for (int w = 0; w < 6; w++) begin
        @(negedge clk);
        if (sl_xfer_ack) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check_eq("b2b_ack_timeout", 0, 1);
        break;
      end
      if (prev >= 0) check_eq("b2b_spacing", cyc - prev, 3);
      prev = cyc;
      acks++;
      ctrl_m   = cur;
      wcount_m = wcount_m + 32'd1;
      cur  = $urandom;
      dbus = cur;
      if (acks == n) sel = 1'b0;
    end
    @(negedge clk);
    check_eq("b2b_final", udo, ctrl_m);
    check_eq("b2b_pulse", {31'h0, upd}, 1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; seq_addr = 1'b0; rnw = 1'b1;
    abus = '0; be = '0; dbus = '0;
    ctrl_m = Def; wcount_m = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_udo", udo, Def);
    check_eq("rst_ack", {31'h0, sl_xfer_ack}, 0);
    check_eq("rst_dbus", sl_dbus, 0);
    check_eq("rst_upd", {31'h0, upd}, 0);
    check_eq("tied_zero", {29'h0, sl_err_ack, sl_retry, sl_tout_sup}, 0);
    rst = 1'b0;

    xfer(Base + 4, 1'b1, 4'h0, 0);
    xfer(Base, 1'b1, 4'h0, 0);
    xfer(Base, 1'b0, 4'hF, 32'h1234_5678);
    check_eq("full_write", udo, 32'h1234_5678);
    xfer(Base, 1'b1, 4'h0, 0);
    xfer(Base + 4, 1'b1, 4'h0, 0);
    xfer(Base, 1'b0, 4'b0101, 32'hAABB_CCDD);
    check_eq("partial_write", udo, 32'h12BB_56DD);
    xfer(Base, 1'b0, 4'b0000, 32'hFFFF_FFFF);
    xfer(Base + 4, 1'b0, 4'hF, 32'h0BAD_F00D);
    xfer(Base + 4, 1'b1, 4'h0, 0);
    xfer(High, 1'b1, 4'h0, 0);

    out_of_window(High + 4, 10);
    out_of_window(Base - 4, 3);
    xfer(Base, 1'b1, 4'h0, 0);

    back_to_back(4);

    @(negedge clk);
    force dut.wcount_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.wcount_q;
    wcount_m = 32'hFFFF_FFFF;
    xfer(Base + 4, 1'b1, 4'h0, 0);
    xfer(Base, 1'b0, 4'b1000, 32'h7700_0000);
    xfer(Base + 4, 1'b1, 4'h0, 0);
    check_eq("wcount_wrap", wcount_m, 32'h0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        out_of_window(High + 1 + $urandom_range(0, 255), 2);
      end else begin
        xfer(Base + $urandom_range(0, 255), 1'($urandom_range(0, 1)), 4'($urandom),
             $urandom);
      end
    end

    // Reset landing in the ACK cycle of a write must discard it.
    @(negedge clk);
    abus = Base; rnw = 1'b0; be = 4'hF; dbus = 32'h5555_5555; sel = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ack", {31'h0, sl_xfer_ack}, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_ack", {31'h0, sl_xfer_ack}, 0);
    check_eq("abort_dbus", sl_dbus, 0);
    check_eq("abort_udo", udo, Def);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ctrl_m = Def; wcount_m = 32'h0;
    @(negedge clk);
    check_eq("abort_udo_after", udo, Def);
    check_eq("abort_upd", {31'h0, upd}, 0);
    xfer(Base + 4, 1'b1, 4'h0, 0);
    xfer(Base, 1'b1, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
